// File: rtl/fpu_arbiter.sv
// Round-robin share of one pipelined FP core; issue 1 cycle after grant, result strobe LAT+2 after handshake.
// No result backpressure: requesters absorb strobes; tag pipe tracks owners and flags schedule mismatches.
module fpu_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int LAT     = 11
) (
    input  logic                clk_in,
    input  logic                rst_in,
    input  logic [NUM_REQ-1:0]  req_valid_in,
    input  logic [31:0]         req_a_in [NUM_REQ],
    input  logic [31:0]         req_b_in [NUM_REQ],
    output logic [NUM_REQ-1:0]  req_ready_out,
    output logic [31:0]         fpu_a_out,
    output logic [31:0]         fpu_b_out,
    output logic                fpu_valid_out,
    input  logic [31:0]         fpu_result_in,
    input  logic                fpu_valid_in,
    output logic [31:0]         res_data_out,
    output logic [NUM_REQ-1:0]  res_valid_out,
    output logic                busy_out,
    output logic                err_out
);

    localparam int TW = $clog2(NUM_REQ);
    localparam int DW = $clog2(LAT + 2);
    localparam logic [NUM_REQ-1:0] ONE = NUM_REQ'(1);

    logic [TW-1:0]      ptr_q, ptr_d;
    logic [TW-1:0]      grant_idx;
    logic               grant_vld;
    logic               grant;

    logic [31:0]        a_q, a_d, b_q, b_d;
    logic               vld_q, vld_d;
    logic [TW-1:0]      tag_q, tag_d;

    logic [LAT-1:0]     pv_q;
    logic [TW-1:0]      pt_q [LAT];

    logic [31:0]        res_data_q, res_data_d;
    logic [NUM_REQ-1:0] res_vld_q, res_vld_d;
    logic               err_q, err_d;
    logic [DW-1:0]      drain_q, drain_d;
    logic               draining;
    logic               strobe;

    always_comb begin : arb
        int idx;
        grant_vld = 1'b0;
        grant_idx = '0;
        idx       = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = (int'(ptr_q) + k) % NUM_REQ;
            if (!grant_vld && req_valid_in[idx]) begin
                grant_vld = 1'b1;
                grant_idx = TW'(idx);
            end
        end
    end

    assign grant         = grant_vld && !rst_in;
    assign req_ready_out = grant ? (ONE << grant_idx) : '0;

    // Tail of the tag pipe lines up with the core's result valid.
    assign draining = (drain_q != '0);
    assign strobe   = fpu_valid_in && pv_q[LAT-1] && !draining;

    always_comb begin
        ptr_d      = ptr_q;
        a_d        = a_q;
        b_d        = b_q;
        vld_d      = 1'b0;
        tag_d      = tag_q;
        res_data_d = res_data_q;
        res_vld_d  = '0;
        err_d      = err_q;
        drain_d    = draining ? (drain_q - DW'(1)) : drain_q;
        if (grant) begin
            ptr_d = TW'((int'(grant_idx) + 1) % NUM_REQ);
            a_d   = req_a_in[grant_idx];
            b_d   = req_b_in[grant_idx];
            vld_d = 1'b1;
            tag_d = grant_idx;
        end
        if (strobe) begin
            res_data_d = fpu_result_in;
            res_vld_d  = ONE << pt_q[LAT-1];
        end
        if (!draining && (fpu_valid_in != pv_q[LAT-1])) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            ptr_q      <= '0;
            a_q        <= '0;
            b_q        <= '0;
            vld_q      <= 1'b0;
            tag_q      <= '0;
            pv_q       <= '0;
            for (int k = 0; k < LAT; k++) begin
                pt_q[k] <= '0;
            end
            res_data_q <= '0;
            res_vld_q  <= '0;
            err_q      <= 1'b0;
            drain_q    <= DW'(LAT + 1);
        end else begin
            ptr_q      <= ptr_d;
            a_q        <= a_d;
            b_q        <= b_d;
            vld_q      <= vld_d;
            tag_q      <= tag_d;
            for (int k = LAT - 1; k > 0; k--) begin
                pv_q[k] <= pv_q[k-1];
                pt_q[k] <= pt_q[k-1];
            end
            pv_q[0]    <= vld_q;
            pt_q[0]    <= tag_q;
            res_data_q <= res_data_d;
            res_vld_q  <= res_vld_d;
            err_q      <= err_d;
            drain_q    <= drain_d;
        end
    end

    assign fpu_a_out     = a_q;
    assign fpu_b_out     = b_q;
    assign fpu_valid_out = vld_q;
    assign res_data_out  = res_data_q;
    assign res_valid_out = res_vld_q;
    assign busy_out      = vld_q || (|pv_q);
    assign err_out       = err_q;

endmodule

// File: tb/tb_fpu_arbiter.sv
// Directed bench for fpu_arbiter with a stub core of fixed latency LAT.
module tb_fpu_arbiter;

    localparam int NUM_REQ = 4;
    localparam int LAT     = 11;

    logic               clk_in;
    logic               rst_in;
    logic [3:0]         req_valid_in;
    logic [31:0]        req_a_in [NUM_REQ];
    logic [31:0]        req_b_in [NUM_REQ];
    logic [3:0]         req_ready_out;
    logic [31:0]        fpu_a_out, fpu_b_out;
    logic               fpu_valid_out;
    logic [31:0]        fpu_result_in;
    logic               fpu_valid_in;
    logic [31:0]        res_data_out;
    logic [3:0]         res_valid_out;
    logic               busy_out, err_out;

    logic               inj_vld;
    logic [31:0]        inj_dat;

    int checks = 0;
    int errors = 0;

    fpu_arbiter #(.NUM_REQ(NUM_REQ), .LAT(LAT)) dut (
        .clk_in        (clk_in),
        .rst_in        (rst_in),
        .req_valid_in  (req_valid_in),
        .req_a_in      (req_a_in),
        .req_b_in      (req_b_in),
        .req_ready_out (req_ready_out),
        .fpu_a_out     (fpu_a_out),
        .fpu_b_out     (fpu_b_out),
        .fpu_valid_out (fpu_valid_out),
        .fpu_result_in (fpu_result_in),
        .fpu_valid_in  (fpu_valid_in),
        .res_data_out  (res_data_out),
        .res_valid_out (res_valid_out),
        .busy_out      (busy_out),
        .err_out       (err_out)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    // Stub core: exact for 1.0+2.0, integer sum elsewhere as a traceable fingerprint; never reset.
    function automatic logic [31:0] core_fn(input logic [31:0] a, input logic [31:0] b);
        if (a == 32'h3f800000 && b == 32'h40000000) return 32'h40400000;
        return a + b;
    endfunction

    logic [LAT-1:0] cm_vld = '0;
    logic [31:0]    cm_dat [LAT];

    always_ff @(posedge clk_in) begin
        cm_vld    <= {cm_vld[LAT-2:0], fpu_valid_out};
        cm_dat[0] <= core_fn(fpu_a_out, fpu_b_out);
        for (int k = 1; k < LAT; k++) cm_dat[k] <= cm_dat[k-1];
    end

    assign fpu_valid_in  = cm_vld[LAT-1] | inj_vld;
    assign fpu_result_in = inj_vld ? inj_dat : cm_dat[LAT-1];

    task automatic next_cycle();
        @(posedge clk_in);
        #1;
    endtask

    task automatic test_reset();
        rst_in       = 1'b1;
        req_valid_in = 4'b1111;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk_in);
            checks++;
            if (req_ready_out !== 4'b0000) begin errors++; $display("FAIL reset_ready c=%0d got %b exp 0000", c, req_ready_out); end
            if (c == 2) begin
                checks++;
                if (fpu_valid_out !== 1'b0 || fpu_a_out !== 32'h0 || fpu_b_out !== 32'h0) begin
                    errors++; $display("FAIL reset_issue got v=%b a=%h b=%h exp 0", fpu_valid_out, fpu_a_out, fpu_b_out);
                end
                checks++;
                if (res_valid_out !== 4'b0000 || res_data_out !== 32'h0) begin
                    errors++; $display("FAIL reset_result got v=%b d=%h exp 0", res_valid_out, res_data_out);
                end
                checks++;
                if (busy_out !== 1'b0 || err_out !== 1'b0) begin
                    errors++; $display("FAIL reset_flags got busy=%b err=%b exp 0 0", busy_out, err_out);
                end
            end
            next_cycle();
        end
        rst_in       = 1'b0;
        req_valid_in = 4'b0000;
        for (int c = 0; c < LAT + 3; c++) next_cycle();
        @(negedge clk_in);
        checks++;
        if (busy_out !== 1'b0 || err_out !== 1'b0) begin
            errors++; $display("FAIL post_reset_idle got busy=%b err=%b exp 0 0", busy_out, err_out);
        end
        next_cycle();
    endtask

    task automatic test_fairness();
        logic [3:0]  exp_rdy, exp_res;
        logic [31:0] exp_dat;
        int          j;
        for (int c = 0; c < 24; c++) begin
            req_valid_in = (c < 8) ? 4'b1111 : 4'b0000;
            for (int i = 0; i < NUM_REQ; i++) begin
                req_a_in[i] = 32'h1000_0000 * (i + 1) + c;
                req_b_in[i] = c;
            end
            @(negedge clk_in);
            exp_rdy = (c < 8) ? (4'b0001 << (c % 4)) : 4'b0000;
            checks++;
            if (req_ready_out !== exp_rdy) begin errors++; $display("FAIL fair_grant c=%0d got %b exp %b", c, req_ready_out, exp_rdy); end
            j       = (c - 13) % 4;
            exp_res = (c >= 13 && c < 21) ? (4'b0001 << j) : 4'b0000;
            checks++;
            if (res_valid_out !== exp_res) begin errors++; $display("FAIL fair_strobe c=%0d got %b exp %b", c, res_valid_out, exp_res); end
            if (c >= 13 && c < 21) begin
                exp_dat = 32'h1000_0000 * (j + 1) + 2 * (c - 13);
                checks++;
                if (res_data_out !== exp_dat) begin errors++; $display("FAIL fair_data c=%0d got %h exp %h", c, res_data_out, exp_dat); end
            end
            next_cycle();
        end
    endtask

    task automatic test_skip_wrap();
        logic [3:0]  exp_rdy, exp_res;
        logic [31:0] exp_dat;
        int          own;
        for (int c = 0; c < 18; c++) begin
            req_valid_in = (c < 4) ? 4'b1010 : 4'b0000;
            for (int i = 0; i < NUM_REQ; i++) begin
                req_a_in[i] = 32'h100 * i + c;
                req_b_in[i] = 32'h0;
            end
            @(negedge clk_in);
            exp_rdy = (c < 4) ? ((c % 2 == 0) ? 4'b0010 : 4'b1000) : 4'b0000;
            checks++;
            if (req_ready_out !== exp_rdy) begin errors++; $display("FAIL skip_grant c=%0d got %b exp %b", c, req_ready_out, exp_rdy); end
            own     = ((c - 13) % 2 == 0) ? 1 : 3;
            exp_res = (c >= 13 && c < 17) ? (4'b0001 << own) : 4'b0000;
            checks++;
            if (res_valid_out !== exp_res) begin errors++; $display("FAIL skip_strobe c=%0d got %b exp %b", c, res_valid_out, exp_res); end
            if (c >= 13 && c < 17) begin
                exp_dat = 32'h100 * own + (c - 13);
                checks++;
                if (res_data_out !== exp_dat) begin errors++; $display("FAIL skip_data c=%0d got %h exp %h", c, res_data_out, exp_dat); end
            end
            next_cycle();
        end
    endtask

    task automatic test_single_op();
        logic [3:0] exp_res;
        for (int c = 0; c < 16; c++) begin
            req_valid_in = (c == 0) ? 4'b0100 : 4'b0000;
            req_a_in[2]  = 32'h3f800000;
            req_b_in[2]  = 32'h40000000;
            @(negedge clk_in);
            if (c == 0) begin
                checks++;
                if (req_ready_out !== 4'b0100) begin errors++; $display("FAIL single_grant got %b exp 0100", req_ready_out); end
            end
            if (c == 1) begin
                checks++;
                if (fpu_valid_out !== 1'b1 || fpu_a_out !== 32'h3f800000 || fpu_b_out !== 32'h40000000) begin
                    errors++; $display("FAIL single_issue got v=%b a=%h b=%h exp 1 3f800000 40000000", fpu_valid_out, fpu_a_out, fpu_b_out);
                end
            end
            exp_res = (c == 13) ? 4'b0100 : 4'b0000;
            checks++;
            if (res_valid_out !== exp_res) begin errors++; $display("FAIL single_strobe c=%0d got %b exp %b", c, res_valid_out, exp_res); end
            if (c == 13) begin
                checks++;
                if (res_data_out !== 32'h40400000) begin errors++; $display("FAIL single_data got %h exp 40400000", res_data_out); end
            end
            if (c >= 1) begin
                checks++;
                if (busy_out !== (c < 13)) begin errors++; $display("FAIL single_busy c=%0d got %b exp %b", c, busy_out, (c < 13)); end
            end
            next_cycle();
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0]  exp_rdy, exp_res;
        logic        exp_iv;
        logic [31:0] exp_dat;
        for (int c = 0; c < 36; c++) begin
            req_valid_in = (c < 20) ? 4'b0001 : 4'b0000;
            req_a_in[0]  = c + 5;
            req_b_in[0]  = c;
            @(negedge clk_in);
            exp_rdy = (c < 20) ? 4'b0001 : 4'b0000;
            checks++;
            if (req_ready_out !== exp_rdy) begin errors++; $display("FAIL b2b_grant c=%0d got %b exp %b", c, req_ready_out, exp_rdy); end
            exp_iv = (c >= 1 && c <= 20);
            checks++;
            if (fpu_valid_out !== exp_iv) begin errors++; $display("FAIL b2b_issue c=%0d got %b exp %b", c, fpu_valid_out, exp_iv); end
            exp_res = (c >= 13 && c <= 32) ? 4'b0001 : 4'b0000;
            checks++;
            if (res_valid_out !== exp_res) begin errors++; $display("FAIL b2b_strobe c=%0d got %b exp %b", c, res_valid_out, exp_res); end
            if (c >= 13 && c <= 32) begin
                exp_dat = 2 * (c - 13) + 5;
                checks++;
                if (res_data_out !== exp_dat) begin errors++; $display("FAIL b2b_data c=%0d got %h exp %h", c, res_data_out, exp_dat); end
            end
            next_cycle();
        end
    endtask

    task automatic test_reset_midflight();
        logic [3:0] exp_rdy, exp_res;
        for (int c = 0; c < 21; c++) begin
            rst_in       = (c == 3);
            req_valid_in = (c <= 4) ? 4'b0001 : 4'b0000;
            req_a_in[0]  = (c == 4) ? 32'hABCD0000 : 32'h5000_0000 + c;
            req_b_in[0]  = 32'h1;
            @(negedge clk_in);
            exp_rdy = (c <= 4 && c != 3) ? 4'b0001 : 4'b0000;
            checks++;
            if (req_ready_out !== exp_rdy) begin errors++; $display("FAIL rst_grant c=%0d got %b exp %b", c, req_ready_out, exp_rdy); end
            if (c == 4) begin
                checks++;
                if (fpu_valid_out !== 1'b0 || busy_out !== 1'b0) begin
                    errors++; $display("FAIL rst_flush got v=%b busy=%b exp 0 0", fpu_valid_out, busy_out);
                end
            end
            if (c == 5) begin
                checks++;
                if (fpu_valid_out !== 1'b1 || fpu_a_out !== 32'hABCD0000) begin
                    errors++; $display("FAIL rst_new_issue got v=%b a=%h exp 1 abcd0000", fpu_valid_out, fpu_a_out);
                end
            end
            if (c >= 4) begin
                exp_res = (c == 17) ? 4'b0001 : 4'b0000;
                checks++;
                if (res_valid_out !== exp_res) begin errors++; $display("FAIL rst_strobe c=%0d got %b exp %b", c, res_valid_out, exp_res); end
                checks++;
                if (err_out !== 1'b0) begin errors++; $display("FAIL rst_drain_err c=%0d got %b exp 0", c, err_out); end
            end
            if (c == 17) begin
                checks++;
                if (res_data_out !== 32'hABCD0001) begin errors++; $display("FAIL rst_new_data got %h exp abcd0001", res_data_out); end
            end
            next_cycle();
        end
    endtask

    task automatic test_schedule_error();
        req_valid_in = 4'b0000;
        for (int c = 0; c < 5; c++) next_cycle();
        for (int c = 0; c < 6; c++) begin
            inj_vld = (c == 0);
            inj_dat = 32'hDEADBEEF;
            @(negedge clk_in);
            checks++;
            if (err_out !== (c >= 1)) begin errors++; $display("FAIL err_flag c=%0d got %b exp %b", c, err_out, (c >= 1)); end
            checks++;
            if (res_valid_out !== 4'b0000) begin errors++; $display("FAIL err_no_strobe c=%0d got %b exp 0000", c, res_valid_out); end
            next_cycle();
        end
        rst_in = 1'b1;
        next_cycle();
        rst_in = 1'b0;
        @(negedge clk_in);
        checks++;
        if (err_out !== 1'b0) begin errors++; $display("FAIL err_clear got %b exp 0", err_out); end
        next_cycle();
    endtask

    initial begin
        rst_in       = 1'b1;
        req_valid_in = 4'b0000;
        inj_vld      = 1'b0;
        inj_dat      = 32'h0;
        for (int i = 0; i < NUM_REQ; i++) begin
            req_a_in[i] = 32'h0;
            req_b_in[i] = 32'h0;
        end
        test_reset();
        test_fairness();
        test_skip_wrap();
        test_single_op();
        test_back_to_back();
        test_reset_midflight();
        test_schedule_error();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
